// File: rtl/bs_pkg.sv
// Shared types and constants for the binary-search arbiter slice.
package bs_pkg;

    localparam int unsigned BS_DATA_W      = 8;
    localparam int unsigned BS_ADDR_W      = 5;
    localparam int unsigned BS_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP,
        DRAIN
    } bs_arb_state_t;

    function automatic int unsigned bs_wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/bs_arbiter_if.sv
// Requester and engine signal bundle for bs_arbiter; master is the arbiter side.
interface bs_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = bs_pkg::BS_DATA_W,
    parameter int unsigned ADDR_W = bs_pkg::BS_ADDR_W,
    parameter int unsigned IdW    = $clog2(N_REQ)
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    resp_valid;
    logic [IdW-1:0]          resp_id;
    logic                    resp_found;
    logic [ADDR_W-1:0]       resp_loc;
    logic                    resp_timeout;
    logic                    busy;
    logic                    eng_start;
    logic [DATA_W-1:0]       eng_A;
    logic                    eng_abort;
    logic                    eng_done;
    logic                    eng_found;
    logic [ADDR_W-1:0]       eng_loc;

    modport master (
        input  req, req_data, eng_done, eng_found, eng_loc,
        output gnt, resp_valid, resp_id, resp_found, resp_loc, resp_timeout, busy,
               eng_start, eng_A, eng_abort
    );

    modport slave (
        output req, req_data, eng_done, eng_found, eng_loc,
        input  gnt, resp_valid, resp_id, resp_found, resp_loc, resp_timeout, busy,
               eng_start, eng_A, eng_abort
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the pointer, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IdW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IdW-1:0]   ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IdW-1:0]   idx_o,
    output logic             any_o
);

    logic [IdW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IdW'((32'(ptr_i) + 32'(k)) % N_REQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bs_arbiter.sv
// Round-robin arbiter sharing one binary_search engine among N_REQ requesters.
// Define BS_ARB_TIMEOUT_EN to enable the RUN-state watchdog (eng_abort / resp_timeout).
module bs_arbiter
    import bs_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = BS_DATA_W,
    parameter int unsigned ADDR_W  = BS_ADDR_W,
    parameter int unsigned TIMEOUT = BS_TIMEOUT_DEF
) (
    input logic          clk,
    input logic          reset,
    bs_arbiter_if.master bus
);

    localparam int unsigned IdW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_param_check
        $error("bs_arbiter: N_REQ must be 2..8 and TIMEOUT at least 2");
    end

    bs_arb_state_t     state_q, state_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [IdW-1:0]    id_q, id_d;
    logic [IdW-1:0]    resp_id_q, resp_id_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              found_q, found_d;
    logic [ADDR_W-1:0] loc_q, loc_d;
    logic              tmo_q, tmo_d;
    logic              armed_q, armed_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IdW-1:0]    pick_idx;
    logic              pick_any;
    logic [DATA_W-1:0] pick_data;
    logic              done_ok;
    logic              abort;

    rr_pick #(
        .N_REQ (N_REQ),
        .IdW   (IdW)
    ) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IdW'(i)) pick_data = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // A Done already high on RUN entry is stale; only trust it after one low sample.
    assign done_ok = bus.eng_done & armed_q;

`ifdef BS_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign abort = (state_q == RUN) && !done_ok && (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        resp_id_d = resp_id_q;
        data_d    = data_q;
        found_d   = found_q;
        loc_d     = loc_q;
        tmo_d     = tmo_q;
        armed_d   = armed_q;
`ifdef BS_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    id_d    = pick_idx;
                    data_d  = pick_data;
                    ptr_d   = IdW'(bs_wrap_inc(32'(pick_idx), N_REQ));
                    armed_d = 1'b0;
`ifdef BS_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.eng_done) armed_d = 1'b1;
                if (done_ok) begin
                    resp_id_d = id_q;
                    found_d   = bus.eng_found;
                    loc_d     = bus.eng_loc;
                    tmo_d     = 1'b0;
                    state_d   = RESP;
                end else if (abort) begin
                    resp_id_d = id_q;
                    found_d   = 1'b0;
                    loc_d     = '0;
                    tmo_d     = 1'b1;
                    state_d   = RESP;
                end else begin
`ifdef BS_ARB_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESP: state_d = DRAIN;
            DRAIN: begin
                if (!bus.eng_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            resp_id_q <= '0;
            data_q    <= '0;
            found_q   <= 1'b0;
            loc_q     <= '0;
            tmo_q     <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            resp_id_q <= resp_id_d;
            data_q    <= data_d;
            found_q   <= found_d;
            loc_q     <= loc_d;
            tmo_q     <= tmo_d;
            armed_q   <= armed_d;
        end
    end

    // Gating with reset keeps gnt at 0 while reset is held, even with requests pending.
    assign bus.gnt          = (state_q == IDLE && !reset) ? pick_gnt : '0;
    assign bus.resp_valid   = (state_q == RESP);
    assign bus.busy         = (state_q != IDLE);
    assign bus.eng_start    = (state_q == RUN);
    assign bus.eng_A        = data_q;
    assign bus.eng_abort    = abort;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_found   = found_q;
    assign bus.resp_loc     = loc_q;
    assign bus.resp_timeout = tmo_q;

endmodule

// File: tb/tb_bs_arbiter.sv
// Directed self-checking bench for bs_arbiter; the engine is driven step by step.
module tb_bs_arbiter;

    logic clk;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    bs_arbiter_if #(.N_REQ(4), .DATA_W(8), .ADDR_W(5)) bus ();

    bs_arbiter #(
        .N_REQ   (4),
        .DATA_W  (8),
        .ADDR_W  (5),
        .TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller sets req; the search is granted, runs lat RUN cycles, responds and drains.
    task automatic run_search(input string tag, input logic [3:0] exp_gnt, input int exp_id,
                              input logic [7:0] exp_a, input logic f, input logic [4:0] l,
                              input int lat, input bit drop);
        #1;
        chk({tag, ".gnt"}, bus.gnt, exp_gnt);
        tick();
        if (drop) bus.req = bus.req & ~exp_gnt;
        chk({tag, ".start"}, bus.eng_start, 1'b1);
        chk({tag, ".eng_A"}, bus.eng_A, exp_a);
        chk({tag, ".gnt_busy"}, bus.gnt, 4'b0000);
        chk({tag, ".abort"}, bus.eng_abort, 1'b0);
        repeat (lat - 1) tick();
        bus.eng_done  = 1'b1;
        bus.eng_found = f;
        bus.eng_loc   = l;
        tick();
        chk({tag, ".valid"}, bus.resp_valid, 1'b1);
        chk({tag, ".id"}, bus.resp_id, exp_id);
        chk({tag, ".found"}, bus.resp_found, f);
        chk({tag, ".loc"}, bus.resp_loc, l);
        chk({tag, ".tmo"}, bus.resp_timeout, 1'b0);
        chk({tag, ".start_resp"}, bus.eng_start, 1'b0);
        bus.eng_done  = 1'b0;
        bus.eng_found = 1'b0;
        bus.eng_loc   = '0;
        tick();
        chk({tag, ".valid_drain"}, bus.resp_valid, 1'b0);
        chk({tag, ".busy_drain"}, bus.busy, 1'b1);
        tick();
        chk({tag, ".idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.req       = '0;
        bus.req_data  = {8'h44, 8'h37, 8'h22, 8'h11};
        bus.eng_done  = 1'b0;
        bus.eng_found = 1'b0;
        bus.eng_loc   = '0;

        tick();
        tick();
        chk("rst.busy", bus.busy, 1'b0);
        chk("rst.gnt", bus.gnt, 4'b0000);
        chk("rst.start", bus.eng_start, 1'b0);
        chk("rst.valid", bus.resp_valid, 1'b0);
        chk("rst.id", bus.resp_id, 0);
        chk("rst.found", bus.resp_found, 1'b0);
        chk("rst.loc", bus.resp_loc, 0);
        chk("rst.eng_A", bus.eng_A, 0);
        chk("rst.tmo", bus.resp_timeout, 1'b0);
        chk("rst.abort", bus.eng_abort, 1'b0);
        reset = 1'b0;
        tick();

        // Fairness: all requests held, pointer starts at 0.
        bus.req = 4'b1111;
        run_search("fair0", 4'b0001, 0, 8'h11, 1'b1, 5'd3, 2, 1'b0);
        run_search("fair1", 4'b0010, 1, 8'h22, 1'b0, 5'd7, 3, 1'b0);
        run_search("fair2", 4'b0100, 2, 8'h37, 1'b1, 5'd12, 4, 1'b0);
        run_search("fair3", 4'b1000, 3, 8'h44, 1'b1, 5'd30, 5, 1'b0);
        run_search("fair4", 4'b0001, 0, 8'h11, 1'b0, 5'd1, 2, 1'b1);
        bus.req = 4'b0000;

        // Single request from id 2, ten-cycle engine latency; pointer is 1.
        bus.req = 4'b0100;
        run_search("single", 4'b0100, 2, 8'h37, 1'b1, 5'd5, 10, 1'b1);

        // Not found; pointer is 3 so the search wraps to requester 0.
        bus.req = 4'b0001;
        run_search("notfound", 4'b0001, 0, 8'h11, 1'b0, 5'd31, 4, 1'b1);

        // Stale Done: held high after start falls while req[1] waits.
        bus.req = 4'b0100;
        #1;
        chk("stale.gnt0", bus.gnt, 4'b0100);
        tick();
        bus.req = 4'b0010;
        chk("stale.start0", bus.eng_start, 1'b1);
        chk("stale.gnt_run", bus.gnt, 4'b0000);
        tick();
        bus.eng_done  = 1'b1;
        bus.eng_found = 1'b1;
        bus.eng_loc   = 5'd12;
        tick();
        chk("stale.valid0", bus.resp_valid, 1'b1);
        chk("stale.id0", bus.resp_id, 2);
        chk("stale.loc0", bus.resp_loc, 12);
        tick();
        chk("stale.busy_d1", bus.busy, 1'b1);
        chk("stale.gnt_d1", bus.gnt, 4'b0000);
        tick();
        chk("stale.gnt_d2", bus.gnt, 4'b0000);
        tick();
        bus.eng_done = 1'b0;
        chk("stale.busy_d3", bus.busy, 1'b1);
        chk("stale.gnt_d3", bus.gnt, 4'b0000);
        tick();
        chk("stale.gnt1", bus.gnt, 4'b0010);
        bus.eng_done = 1'b1;
        tick();
        bus.req = 4'b0000;
        chk("stale.start1", bus.eng_start, 1'b1);
        chk("stale.eng_A1", bus.eng_A, 8'h22);
        tick();
        chk("stale.ignored", bus.eng_start, 1'b1);
        chk("stale.novalid", bus.resp_valid, 1'b0);
        bus.eng_done = 1'b0;
        tick();
        chk("stale.still_run", bus.eng_start, 1'b1);
        bus.eng_done  = 1'b1;
        bus.eng_found = 1'b1;
        bus.eng_loc   = 5'd9;
        tick();
        chk("stale.valid1", bus.resp_valid, 1'b1);
        chk("stale.id1", bus.resp_id, 1);
        chk("stale.found1", bus.resp_found, 1'b1);
        chk("stale.loc1", bus.resp_loc, 9);
        bus.eng_done  = 1'b0;
        bus.eng_found = 1'b0;
        bus.eng_loc   = '0;
        tick();
        tick();
        chk("stale.idle", bus.busy, 1'b0);

        // Reset four cycles after a grant; pointer is 2, requester 0 wins.
        bus.req = 4'b0001;
        #1;
        chk("rstrun.gnt", bus.gnt, 4'b0001);
        tick();
        bus.req = 4'b0000;
        tick();
        tick();
        tick();
        chk("rstrun.pre_start", bus.eng_start, 1'b1);
        reset = 1'b1;
        #1;
        chk("rstrun.start", bus.eng_start, 1'b0);
        chk("rstrun.busy", bus.busy, 1'b0);
        chk("rstrun.valid", bus.resp_valid, 1'b0);
        chk("rstrun.found", bus.resp_found, 1'b0);
        chk("rstrun.loc", bus.resp_loc, 0);
        chk("rstrun.id", bus.resp_id, 0);
        chk("rstrun.eng_A", bus.eng_A, 0);
        chk("rstrun.gnt0", bus.gnt, 4'b0000);
        tick();
        reset = 1'b0;
        tick();
        chk("rstrun.novalid", bus.resp_valid, 1'b0);
        bus.req = 4'b0100;
        run_search("postrst", 4'b0100, 2, 8'h37, 1'b1, 5'd17, 3, 1'b1);

`ifdef BS_ARB_TIMEOUT_EN
        // Watchdog: Done never comes; pointer is 3 so requester 1 wins.
        bus.req = 4'b0010;
        #1;
        chk("tmo.gnt", bus.gnt, 4'b0010);
        tick();
        bus.req = 4'b0000;
        repeat (14) tick();
        chk("tmo.abort15", bus.eng_abort, 1'b0);
        tick();
        chk("tmo.abort16", bus.eng_abort, 1'b1);
        tick();
        chk("tmo.valid", bus.resp_valid, 1'b1);
        chk("tmo.flag", bus.resp_timeout, 1'b1);
        chk("tmo.found", bus.resp_found, 1'b0);
        chk("tmo.loc", bus.resp_loc, 0);
        chk("tmo.id", bus.resp_id, 1);
        chk("tmo.abort_off", bus.eng_abort, 1'b0);
        tick();
        tick();
        chk("tmo.idle", bus.busy, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bs_arbiter.md
# bs_arbiter

Round-robin arbiter that shares one `binary_search` engine (8-bit target, 32-entry memory, 5-bit location) among several requesters. It grants one request at a time, drives the engine's start/target inputs, waits for Done, and returns Found/Loc tagged with the requester ID. It sits between requester logic (switch/UI front-ends, test sequencers) and the single search datapath in the `part2`-level design.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: target value width.
- `ADDR_W`, 5: location width.
- `TIMEOUT`, 64: watchdog limit in cycles; used only with the macro.

- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `req` in N_REQ: per-requester request level.
- `req_data` in N_REQ*DATA_W: target values; requester i occupies bits [i*DATA_W +: DATA_W].
- `gnt` out N_REQ: one-hot acceptance pulse.
- `resp_valid` out 1: one-cycle result pulse.
- `resp_id` out $clog2(N_REQ): requester that owns the result.
- `resp_found` out 1: engine Found.
- `resp_loc` out ADDR_W: engine Loc.
- `resp_timeout` out 1: search aborted by the watchdog.
- `busy` out 1: high when state is not IDLE.
- `eng_start` out 1: engine start, level.
- `eng_A` out DATA_W: engine target.
- `eng_abort` out 1: one-cycle engine reset pulse.
- `eng_done` in 1: engine Done.
- `eng_found` in 1: engine Found.
- `eng_loc` in ADDR_W: engine Loc.

## Operation
- Reset value of every output is 0. The state goes to IDLE, the priority pointer to 0, and the captured ID/data to 0. A reset asserted mid-search drops `eng_start` immediately and issues no response.
- Requester rule: hold `req` high with stable `req_data` until `gnt[i]` is seen. Drop `req` or present the next value the cycle after `gnt`.
- States:
  - IDLE: if any `req` is high, `gnt` asserts combinationally to the winner. At the clock edge, latch the winner ID and its data, then go to RUN.
  - RUN: `eng_start`=1 and `eng_A`=latched data. When `eng_done`=1 is sampled, capture `eng_found`/`eng_loc` and go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, with `eng_start`=0. Go to DRAIN.
  - DRAIN: `eng_start`=0. When `eng_done`=0 is sampled, go to IDLE.
- Round-robin: the search begins at the pointer and wraps modulo N_REQ. After a grant to w, the pointer becomes (w+1) mod N_REQ. With the pointer at p, requester p wins; if req[p] is low, the search moves to p+1, and so on.
- `gnt` is 0 outside IDLE. Requests arriving while busy wait; nothing is queued beyond the `req` levels.
- `resp_id`, `resp_found`, `resp_loc` and `resp_timeout` are registered. They hold their last value between pulses.
- If `eng_done` is already high on entry to RUN, it is treated as a stale Done: it is ignored until it has been sampled low once in RUN.

## Timing
- Grant at cycle T. `eng_start` rises at T+1.
- Done sampled at cycle D. `resp_valid` fires at D+1.
- The earliest next grant is at D+3 (RESP, then one DRAIN cycle with Done low, then IDLE).
- Minimum gap between two `resp_valid` pulses is 4 cycles plus the engine latency.

## Configuration
- `BS_ARB_TIMEOUT_EN` defined:
  - A counter clears on RUN entry and increments each RUN cycle.
  - On reaching TIMEOUT-1 without a valid Done, `eng_abort` pulses one cycle and the state goes to RESP.
  - That response carries `resp_timeout`=1, `resp_found`=0, `resp_loc`=0.
- Not defined: RUN waits indefinitely. `eng_abort` and `resp_timeout` are tied to 0 and the ports remain present.

## Structure
- Package `bs_pkg` holds:
  - state enum `bs_arb_state_t` {IDLE, RUN, RESP, DRAIN};
  - constants `BS_DATA_W`=8 and `BS_ADDR_W`=5 (parameter defaults reference them);
  - `BS_TIMEOUT_DEF`=64.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are `req` and the pointer; outputs are a one-hot grant, the encoded index and an any-request flag.

## Test plan
- Single request: req[2]=1, data=8'h37, engine model returns Done after 10 cycles with Loc=5 and Found=1. Expect gnt[2] pulse, eng_A=8'h37, then resp_valid with id=2, found=1, loc=5.
- Fairness: req=4'b1111 held, pointer at 0. Expect grants in order 0,1,2,3,0, one per search.
- Stale Done: engine holds Done high for 3 cycles after start falls, while req[1] is pending. Expect no grant until Done has gone low; the next search captures only a fresh Done.
- Not found: engine returns Found=0, Loc=31. Expect resp_found=0 and resp_loc=31.
- Reset mid-RUN: assert reset 4 cycles after the grant. Expect all outputs 0 the same cycle, no resp_valid, and a clean grant after release.
- Timeout (with macro, TIMEOUT=16): engine never asserts Done. Expect eng_abort at cycle 16 of RUN, then resp_valid with timeout=1, found=0, loc=0.
